// File: rtl/interp_fir_x2.sv
// 2x polyphase interpolating FIR, audio output path.
// One sample in, two samples out (phase 0 then phase 1).
// A single multiplier is time-shared by a five-state FSM,
// with one tap processed per cycle.

// Saturate a wide signed accumulator value down to W bits.
module interp_fir_x2_sat #(
   parameter int W     = 32,
   parameter int ACC_W = 42
) (
   input  logic signed [ACC_W-1:0] x_i,
   output logic signed [W-1:0]     y_o
);

   logic [ACC_W-W:0] upper;
   logic             fits;

   assign upper = x_i[ACC_W-1:W-1];

   // The value fits when every bit above the W-bit sign bit matches that sign bit.
   always_comb begin
      fits = (&upper) | (~|upper);
      if (fits)
         y_o = x_i[W-1:0];
      else if (x_i[ACC_W-1])
         y_o = {1'b1, {(W-1){1'b0}}};
      else
         y_o = {1'b0, {(W-1){1'b1}}};
   end

endmodule

// Coefficient ROM. It is indexed by tap number 2k+p.
// The centre taps (157) need one bit more than H signed bits, so the ROM is H+1 bits wide.
module interp_fir_x2_coef #(
   parameter int CW = 9
) (
   input  logic [2:0]           idx_i,
   output logic signed [CW-1:0] c_o
);

   // 8-tap symmetric lowpass. Each polyphase half sums to 128.
   always_comb begin
      case (idx_i)
         3'd0:    c_o = CW'(-2);
         3'd1:    c_o = CW'(8);
         3'd2:    c_o = CW'(-35);
         3'd3:    c_o = CW'(157);
         3'd4:    c_o = CW'(157);
         3'd5:    c_o = CW'(-35);
         3'd6:    c_o = CW'(8);
         default: c_o = CW'(-2);
      endcase
   end

endmodule

module interp_fir_x2 #(
   parameter int W = 32,
   parameter int H = 8
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [W-1:0] Xin,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [W-1:0] Y
);

   localparam int NTAP  = 4;
   localparam int CW    = H + 1;
   localparam int PW    = W + CW;
   localparam int ACC_W = W + H + 2;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MAC0 = 3'd1;
   localparam logic [2:0] S_OUT0 = 3'd2;
   localparam logic [2:0] S_MAC1 = 3'd3;
   localparam logic [2:0] S_OUT1 = 3'd4;

   logic [2:0]                   state_q, state_d;
   logic [1:0]                   k_q, k_d;
   logic signed [ACC_W-1:0]      acc_q, acc_d;
   logic [NTAP-1:0][W-1:0]       d_q, d_d;
   logic signed [W-1:0]          y_q, y_d;
   logic                         ov_q, ov_d;

   logic                         phase;
   logic signed [CW-1:0]         coef;
   logic [W-1:0]                 d_sel;
   logic signed [PW-1:0]         d_ext, c_ext, prod;
   logic signed [ACC_W-1:0]      acc_sum, shifted;
   logic signed [W-1:0]          sat_val;
   logic                         last_tap;

   // The odd polyphase branch is used only while the FSM is in MAC1.
   assign phase    = (state_q == S_MAC1);
   assign last_tap = (k_q == 2'd3);
   assign d_sel    = d_q[k_q];

   interp_fir_x2_coef #(.CW(CW)) u_coef (
      .idx_i ({k_q, phase}),
      .c_o   (coef)
   );

   // Both multiplier operands are widened to the product width first, so the multiply is full precision.
   assign d_ext   = {{CW{d_sel[W-1]}}, d_sel};
   assign c_ext   = {{W{coef[CW-1]}}, coef};
   assign prod    = d_ext * c_ext;
   assign acc_sum = acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};

   // The arithmetic shift floors toward -inf. The final tap result goes straight to the saturator.
   assign shifted = acc_sum >>> (H - 1);

   interp_fir_x2_sat #(.W(W), .ACC_W(ACC_W)) u_sat (
      .x_i (shifted),
      .y_o (sat_val)
   );

   // Next-state logic for the FSM, the MAC datapath, the delay line and the output register.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      acc_d   = acc_q;
      d_d     = d_q;
      y_d     = y_q;
      ov_d    = ov_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               d_d     = {d_q[NTAP-2:0], Xin};
               acc_d   = '0;
               k_d     = '0;
               state_d = S_MAC0;
            end
         end
         S_MAC0, S_MAC1: begin
            acc_d = acc_sum;
            k_d   = k_q + 2'd1;
            if (last_tap) begin
               y_d     = sat_val;
               ov_d    = 1'b1;
               state_d = (state_q == S_MAC0) ? S_OUT0 : S_OUT1;
            end
         end
         S_OUT0: begin
            if (ov_q && out_ready) begin
               ov_d    = 1'b0;
               acc_d   = '0;
               k_d     = '0;
               state_d = S_MAC1;
            end
         end
         S_OUT1: begin
            if (ov_q && out_ready) begin
               ov_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            ov_d    = 1'b0;
         end
      endcase
   end

   // State registers. Reset discards any partial result.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         acc_q   <= '0;
         d_q     <= '0;
         y_q     <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         d_q     <= d_d;
         y_q     <= y_d;
         ov_q    <= ov_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = ov_q;
   assign Y         = y_q;

endmodule

// File: tb/tb_interp_fir_x2.sv
// Directed bench for interp_fir_x2.
// A reference model pushes two expected outputs per accepted sample.
// Each output handshake pops one expected value and compares it with Y.
module tb_interp_fir_x2;

   localparam int W = 32;
   localparam int H = 8;
   localparam longint MAXV = 64'sd2147483647;
   localparam longint MINV = -MAXV - 1;

   logic                clock = 1'b0;
   logic                reset_n;
   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] Xin;
   logic                out_valid;
   logic                out_ready;
   logic signed [W-1:0] Y;

   interp_fir_x2 #(.W(W), .H(H)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Xin       (Xin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Y         (Y)
   );

   always #5 clock = ~clock;

   int     n_vec = 0;
   int     n_err = 0;
   int     cyc = 0;
   int     last_acc = -1;
   int     acc_cnt = 0;
   bit     acc_flag = 0;
   bit     tput_en = 0;
   longint sb[$];
   longint dm[4];
   int     hc[8] = '{-2, 8, -35, 157, 157, -35, 8, -2};

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint model_phase(input int p);
      longint s = 0;
      for (int k = 0; k < 4; k++) s += longint'(hc[2*k+p]) * dm[k];
      s = s >>> (H - 1);
      if (s > MAXV) s = MAXV;
      else if (s < MINV) s = MINV;
      return s;
   endfunction

   // Look at the handshakes that the coming rising edge will complete.
   task automatic observe();
      if (out_valid && out_ready) begin
         if (sb.size() == 0) chk("unexpected_output", 64'(Y), 64'sd0 - 64'sd99999);
         else chk("Y", Y, sb.pop_front());
      end
      if (in_valid && in_ready) begin
         dm[3] = dm[2]; dm[2] = dm[1]; dm[1] = dm[0]; dm[0] = longint'(Xin);
         sb.push_back(model_phase(0));
         sb.push_back(model_phase(1));
         if (tput_en && last_acc >= 0) chk("accept_period", cyc - last_acc, 11);
         last_acc = cyc;
         acc_cnt++;
         acc_flag = 1;
      end
   endtask

   task automatic tick();
      observe();
      @(negedge clock);
      cyc++;
   endtask

   task automatic send(input logic signed [W-1:0] x);
      int n = 0;
      in_valid = 1'b1;
      Xin      = x;
      acc_flag = 0;
      while (!acc_flag && n < 50) begin tick(); n++; end
      chk("accept_timeout", acc_flag, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin tick(); n++; end
      chk("drain_timeout", sb.size(), 0);
   endtask

   initial begin
      int n;
      int seen;
      logic signed [W-1:0] y0;
      logic signed [W-1:0] imp [8];
      imp = '{1000, 0, 0, 0, 0, 0, 0, 0};
      for (int i = 0; i < 4; i++) dm[i] = 0;

      // 1: reset values, then a quiet idle period
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; Xin = '0;
      repeat (3) @(negedge clock);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_Y", Y, 0);
      reset_n = 1'b1;
      @(negedge clock);
      chk("rst_in_ready", in_ready, 1);
      seen = 0;
      repeat (10) begin tick(); if (out_valid) seen++; end
      chk("idle_no_output", seen, 0);

      // 2: impulse response, with a check of the phase-0 latency on the first sample
      send(imp[0]);
      n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      chk("latency_phase0", n, 4);
      drain();
      for (int i = 1; i < 8; i++) begin send(imp[i]); drain(); end

      // 3: DC gain
      for (int i = 0; i < 6; i++) begin send(1000); drain(); end

      // 4: saturation at both rails
      send(32'sh80000000); drain();
      send(32'sh80000000); drain();
      send(32'sh7FFFFFFF); drain();
      send(32'sh7FFFFFFF); drain();

      // 5: backpressure held in OUT0
      out_ready = 1'b0;
      send(-12345);
      n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      chk("bp_out_valid_rise", out_valid, 1);
      y0 = Y;
      chk("bp_first_value", y0, sb[0]);
      for (int i = 0; i < 20; i++) begin
         in_valid = i[0];
         Xin      = $urandom;
         tick();
         chk("bp_Y_hold", Y, y0);
         chk("bp_valid_hold", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

      // 6: throughput with both handshakes held, then reset during MAC1
      last_acc = -1; acc_cnt = 0; tput_en = 1; in_valid = 1'b1;
      n = 0;
      while (acc_cnt < 5 && n < 200) begin Xin = $urandom; tick(); n++; end
      chk("tput_accepts", acc_cnt, 5);
      acc_flag = 0; n = 0;
      while (!acc_flag && n < 50) begin tick(); n++; end
      repeat (6) tick();
      reset_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_Y", Y, 0);
      tput_en = 0;
      sb.delete();
      for (int i = 0; i < 4; i++) dm[i] = 0;
      in_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("post_rst_in_ready", in_ready, 1);
      for (int i = 0; i < 8; i++) begin send(imp[i]); drain(); end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
